// File: rtl/mtx_pkg.sv
// Shared parameters and state encoding for the 4x4 matrix product path.
// Imported by the multiplier and the result collector.
package mtx_pkg;

  localparam int N  = 4;
  localparam int DW = 18;
  localparam int AW = 4;
  localparam int TW = 20;
  localparam int NN = N * N;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    DONE    = 2'b10,
    ERR     = 2'b11
  } state_e;

  // Row-major diagonal elements sit every N+1 words.
  function automatic logic is_diag(input logic [AW-1:0] idx);
    return (int'(idx) % (N + 1)) == 0;
  endfunction

endpackage

// File: rtl/mtx_buf_ram.sv
// N*N x DW frame buffer: one write port, one registered read port.
// Read register resets to zero; array contents are not reset.
module mtx_buf_ram
  import mtx_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [NN];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mtx_result_collector.sv
// Captures a 16-word product frame, tracks trace and max on the fly,
// then serves random-access reads once the frame is complete.
module mtx_result_collector
  import mtx_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mp_valid,
  input  logic [DW-1:0] mp_in,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [TW-1:0] trace,
  output logic [DW-1:0] max_val,
  output logic [AW-1:0] max_idx,
  output logic          done,
  output logic          err
);

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] trace_q, trace_d;
  logic [DW-1:0] max_q, max_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          rd_valid_q, rd_valid_d;
  logic          cap;
  logic          re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    trace_d = trace_q;
    max_d   = max_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    re      = 1'b0;
    if (start) begin
      state_d = IDLE;
      cnt_d   = '0;
      trace_d = '0;
      max_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mp_valid) begin
            cap     = 1'b1;
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (mp_valid) begin
            cap = 1'b1;
            if (cnt_q == AW'(NN - 1)) begin
              state_d = DONE;
            end
          end else begin
            state_d = ERR;
          end
        end
        DONE:    re = rd_en;
        ERR:     re = 1'b0;
        default: re = 1'b0;
      endcase
      // Strict compare so ties keep the earliest index.
      if (cap) begin
        cnt_d = cnt_q + 1'b1;
        if (is_diag(cnt_q)) begin
          trace_d = trace_q + TW'(mp_in);
        end
        if (mp_in > max_q) begin
          max_d = mp_in;
          idx_d = cnt_q;
        end
      end
    end
    rd_valid_d = re;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      trace_q    <= '0;
      max_q      <= '0;
      idx_q      <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      trace_q    <= trace_d;
      max_q      <= max_d;
      idx_q      <= idx_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  mtx_buf_ram u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cap & rst_n),
    .waddr (cnt_q),
    .wdata (mp_in),
    .re    (re),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign rd_valid = rd_valid_q;
  assign trace    = trace_q;
  assign max_val  = max_q;
  assign max_idx  = idx_q;
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);

endmodule

// File: tb/tb_mtx_result_collector.sv
// Scoreboarded bench for mtx_result_collector: random frames against
// a frame-level reference model, reads checked by a separate monitor.
module tb_mtx_result_collector;
  import mtx_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n, start, mp_valid, rd_en;
  logic [DW-1:0] mp_in;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data, max_val;
  logic          rd_valid, done, err;
  logic [TW-1:0] trace;
  logic [AW-1:0] max_idx;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            a;
    int            c;
  } rd_exp_t;
  rd_exp_t sbq[$];

  logic [DW-1:0] fr    [NN];
  logic [DW-1:0] mem_m [NN];
  logic [TW-1:0] m_tr, lt;
  logic [DW-1:0] m_mx, lm;
  logic [AW-1:0] m_mi, li;

  mtx_result_collector dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mp_valid (mp_valid),
    .mp_in    (mp_in),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .trace    (trace),
    .max_val  (max_val),
    .max_idx  (max_idx),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Read monitor: every rd_valid must match the oldest pending read.
  always @(negedge clk) begin
    rd_exp_t e;
    if (rd_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rd_unexp: rd_valid=1 data=%0h, none pending",
                 rd_data);
      end else begin
        e = sbq.pop_front();
        if (rd_data !== e.d || cyc_n != e.c) begin
          errors++;
          $display("FAIL rd_data[%0d]: got %0h @%0d want %0h @%0d",
                   e.a, rd_data, cyc_n, e.d, e.c);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 7));
    return DW'($urandom);
  endfunction

  task automatic rnd_frame();
    for (int i = 0; i < NN; i++) fr[i] = rnd_word();
  endtask

  // Reference: trace is the sum of A[i][i]; max is the first largest.
  task automatic model();
    m_tr = '0;
    m_mx = '0;
    m_mi = '0;
    for (int i = 0; i < N; i++) m_tr = m_tr + TW'(fr[i * N + i]);
    for (int i = 0; i < NN; i++) begin
      if (fr[i] > m_mx) begin
        m_mx = fr[i];
        m_mi = AW'(i);
      end
    end
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_trace"},    32'(trace),    0);
    chk({t, "_max"},      32'(max_val),  0);
    chk({t, "_idx"},      32'(max_idx),  0);
    chk({t, "_done"},     32'(done),     0);
    chk({t, "_err"},      32'(err),      0);
    chk({t, "_rd_valid"}, 32'(rd_valid), 0);
    chk({t, "_rd_data"},  32'(rd_data),  0);
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic feed(input int from, input int len);
    for (int i = 0; i < len; i++) begin
      mp_valid = 1'b1;
      mp_in    = fr[from + i];
      cyc();
    end
    mp_valid = 1'b0;
    mp_in    = rnd_word();
  endtask

  task automatic full_frame(input string t);
    model();
    for (int i = 0; i < NN; i++) begin
      mp_valid = 1'b1;
      mp_in    = fr[i];
      if (i == NN - 1) chk({t, "_done_pre"}, 32'(done), 0);
      cyc();
    end
    mp_valid = 1'b0;
    for (int i = 0; i < NN; i++) mem_m[i] = fr[i];
    chk({t, "_done"},  32'(done),    1);
    chk({t, "_err"},   32'(err),     0);
    chk({t, "_trace"}, 32'(trace),   32'(m_tr));
    chk({t, "_max"},   32'(max_val), 32'(m_mx));
    chk({t, "_idx"},   32'(max_idx), 32'(m_mi));
  endtask

  task automatic issue_rd(input int a);
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    sbq.push_back('{mem_m[a], a, cyc_n + 1});
    cyc();
    rd_en = 1'b0;
  endtask

  task automatic drain(input string t);
    rd_en = 1'b0;
    cyc();
    cyc();
    chk({t, "_drain"}, 32'(sbq.size()), 0);
  endtask

  task automatic read_all(input string t, input bit rnd);
    for (int i = 0; i < NN; i++) begin
      issue_rd(rnd ? int'($urandom_range(0, NN - 1)) : i);
    end
    drain(t);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    mp_valid = 1'b0;
    mp_in    = '0;
    rd_en    = 1'b0;
    rd_addr  = '0;
    cyc();
    cyc();
    chk_reset("por");
    rst_n = 1'b1;

    // Ascending frame 1..16
    do_start();
    for (int i = 0; i < NN; i++) fr[i] = DW'(i + 1);
    full_frame("seq");
    chk("seq_trace_k", 32'(trace),   34);
    chk("seq_max_k",   32'(max_val), 16);
    chk("seq_idx_k",   32'(max_idx), 15);
    read_all("seq", 1'b0);

    // Saturated diagonal must not wrap
    rnd_frame();
    for (int d = 0; d < N; d++) fr[d * (N + 1)] = 18'h3FFFF;
    do_start();
    full_frame("diag");
    chk("diag_trace_k", 32'(trace), 32'h000FFFFC);
    read_all("diag", 1'b1);

    // Tie on the maximum keeps the lower index
    for (int i = 0; i < NN; i++) fr[i] = DW'($urandom_range(0, 18'h1FF));
    fr[3] = 18'h200;
    fr[9] = 18'h200;
    do_start();
    full_frame("tie");
    chk("tie_max_k", 32'(max_val), 32'h200);
    chk("tie_idx_k", 32'(max_idx), 3);

    // Truncated frame
    do_start();
    rnd_frame();
    feed(0, 7);
    cyc();
    chk("trunc_err",  32'(err),  1);
    chk("trunc_done", 32'(done), 0);
    rd_en   = 1'b1;
    rd_addr = AW'(2);
    cyc();
    rd_en = 1'b0;
    chk("trunc_rd_valid", 32'(rd_valid), 0);
    cyc();
    chk("trunc_err_sticky", 32'(err), 1);
    do_start();
    chk("trunc_err_clr", 32'(err), 0);
    rnd_frame();
    full_frame("recov");
    read_all("recov", 1'b1);

    // start collides with word 5; the rest forms a short frame
    do_start();
    rnd_frame();
    feed(0, 5);
    mp_valid = 1'b1;
    mp_in    = fr[5];
    start    = 1'b1;
    cyc();
    start = 1'b0;
    chk("mid_trace", 32'(trace),   0);
    chk("mid_max",   32'(max_val), 0);
    chk("mid_idx",   32'(max_idx), 0);
    chk("mid_done",  32'(done),    0);
    chk("mid_err",   32'(err),     0);
    feed(6, 10);
    lt = TW'(fr[6]) + TW'(fr[11]);
    lm = '0;
    li = '0;
    for (int i = 0; i < 10; i++) begin
      if (fr[6 + i] > lm) begin
        lm = fr[6 + i];
        li = AW'(i);
      end
    end
    chk("short_trace", 32'(trace),   32'(lt));
    chk("short_max",   32'(max_val), 32'(lm));
    chk("short_idx",   32'(max_idx), 32'(li));
    chk("short_done",  32'(done),    0);
    cyc();
    chk("short_err",   32'(err),     1);
    chk("short_done2", 32'(done),    0);
    chk("short_trace2", 32'(trace),  32'(lt));

    // Reset mid-capture
    do_start();
    rnd_frame();
    for (int i = 0; i < 5; i++) begin
      mp_valid = 1'b1;
      mp_in    = fr[i];
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n    = 1'b1;
    mp_valid = 1'b0;
    chk_reset("rst_cap");

    // Reset in DONE during a read
    do_start();
    rnd_frame();
    full_frame("pre_rst");
    issue_rd(4);
    issue_rd(11);
    rd_en   = 1'b1;
    rd_addr = AW'(7);
    rst_n   = 1'b0;
    cyc();
    rst_n = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b1;
    chk_reset("rst_done");
    chk("rst_done_sb", 32'(sbq.size()), 0);

    // Stray mp_valid pulses while DONE change nothing
    do_start();
    rnd_frame();
    full_frame("frz");
    for (int i = 0; i < 3; i++) begin
      mp_valid = 1'b1;
      mp_in    = 18'h3FFFF - DW'(i);
      cyc();
    end
    mp_valid = 1'b0;
    chk("frz_done",  32'(done),    1);
    chk("frz_trace", 32'(trace),   32'(m_tr));
    chk("frz_max",   32'(max_val), 32'(m_mx));
    chk("frz_idx",   32'(max_idx), 32'(m_mi));
    read_all("frz", 1'b0);

    // Random frames with gapped random reads
    for (int f = 0; f < 20; f++) begin
      do_start();
      rnd_frame();
      full_frame("rnd");
      for (int k = 0; k < 12; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          rd_en = 1'b0;
          cyc();
        end else begin
          issue_rd(int'($urandom_range(0, NN - 1)));
        end
      end
      drain("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
